// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the CLK_DIV change sequencer.
package clk_div_pkg;

  localparam int DEF_RATIO_WIDTH = 5;
  localparam int DEF_RESET_RATIO = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN,
    ST_LOAD,
    ST_RESUME,
    ST_FINISH
  } state_e;

  // A divide ratio of zero has no meaning for CLK_DIV and is rejected.
  function automatic logic ratio_legal(input logic [31:0] ratio);
    return ratio != '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         idx_o
);

  logic found;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (j >= 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = 2'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (j < 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Arbitrates divide-ratio change requests and sequences a glitch-safe
// ratio change on one CLK_DIV instance (gate, settle, load, resume, report).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int RATIO_WIDTH   = DEF_RATIO_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_RATIO   = DEF_RESET_RATIO
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RUN,
  input  logic [NUM_REQ-1:0]             REQ_VALID,
  input  logic [NUM_REQ*RATIO_WIDTH-1:0] REQ_RATIO,
  output logic [NUM_REQ-1:0]             REQ_READY,
  output logic                           DONE,
  output logic [1:0]                     DONE_ID,
  output logic                           ERR,
  output logic                           BUSY,
  output logic                           DIV_EN,
  output logic [RATIO_WIDTH-1:0]         DIV_RATIO
);

  localparam int RATIO_MAX = (1 << RATIO_WIDTH) - 1;
  localparam int CNT_MAX   = (SETTLE_CYCLES > RATIO_MAX) ? SETTLE_CYCLES : RATIO_MAX;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  state_e                 state_q;
  logic [1:0]             ptr_q;
  logic [1:0]             ptr_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             id_q;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [NUM_REQ-1:0]     ready_q;
  logic                   done_q;
  logic                   err_q;
  logic                   busy_q;
  logic [1:0]             done_id_q;
  logic                   div_en_q;
  logic [RATIO_WIDTH-1:0] div_ratio_q;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [1:0]             arb_idx;
  logic [RATIO_WIDTH-1:0] win_ratio;
  logic                   ratio_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign ratio_ok = ratio_legal(32'(ratio_q));

  // Select the winner's ratio slice and the pointer value that follows it.
  always_comb begin
    win_ratio = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (arb_idx == 2'(j)) begin
        win_ratio = REQ_RATIO[j*RATIO_WIDTH +: RATIO_WIDTH];
      end
    end
    ptr_d = (arb_idx == 2'(NUM_REQ - 1)) ? '0 : arb_idx + 2'd1;
  end

  // Sequencer FSM with all outputs registered; DIV_EN tracks RUN except while draining.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      ratio_q     <= '0;
      ready_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_id_q   <= '0;
      div_en_q    <= 1'b0;
      div_ratio_q <= RATIO_WIDTH'(RESET_RATIO);
    end else begin
      ready_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      div_en_q <= RUN;
      case (state_q)
        ST_IDLE: begin
          if (|REQ_VALID) begin
            state_q <= ST_GRANT;
            busy_q  <= 1'b1;
            ready_q <= arb_gnt;
            id_q    <= arb_idx;
            ratio_q <= win_ratio;
            ptr_q   <= ptr_d;
          end
        end
        ST_GRANT: begin
          if (!ratio_ok || (ratio_q == div_ratio_q)) begin
            state_q   <= ST_FINISH;
            done_q    <= 1'b1;
            err_q     <= !ratio_ok;
            done_id_q <= id_q;
          end else begin
            state_q  <= ST_DRAIN;
            div_en_q <= 1'b0;
            cnt_q    <= CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          // New ratio becomes visible on the final drain cycle, one before re-enable.
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            div_ratio_q <= ratio_q;
          end
          if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
            state_q <= ST_LOAD;
          end else begin
            div_en_q <= 1'b0;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          state_q <= ST_RESUME;
          cnt_q   <= CNT_W'(1);
        end
        ST_RESUME: begin
          if (cnt_q == CNT_W'(ratio_q)) begin
            state_q   <= ST_FINISH;
            done_q    <= 1'b1;
            done_id_q <= id_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY = ready_q;
  assign DONE      = done_q;
  assign DONE_ID   = done_id_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign DIV_EN    = div_en_q;
  assign DIV_RATIO = div_ratio_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: timeline model of each change sequence plus directed literals.
module tb_clk_div_ctrl;

  localparam int NREQ   = 2;
  localparam int RW     = 5;
  localparam int SETTLE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [1:0]    valid;
  logic [RW-1:0] r0, r1;
  logic [1:0]    ready;
  logic          done, err, busy, div_en;
  logic [1:0]    done_id;
  logic [RW-1:0] div_ratio;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .NUM_REQ       (NREQ),
    .RATIO_WIDTH   (RW),
    .SETTLE_CYCLES (SETTLE),
    .RESET_RATIO   (1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RUN       (run),
    .REQ_VALID (valid),
    .REQ_RATIO ({r1, r0}),
    .REQ_READY (ready),
    .DONE      (done),
    .DONE_ID   (done_id),
    .ERR       (err),
    .BUSY      (busy),
    .DIV_EN    (div_en),
    .DIV_RATIO (div_ratio)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: each granted change is described by its cycle timeline
  // (grant H, gated window, ratio switch cycle, done cycle).
  int            m_h = -100, m_done = -100, m_lo = 0, m_hi = -1, m_rt = 0;
  int            m_ptr = 0, m_id = 0;
  logic          m_err = 1'b0, m_run = 1'b0;
  logic [1:0]    m_gnt = '0;
  logic [RW-1:0] m_old = 1, m_new = 1;

  always @(posedge clk) begin
    int            w, idx;
    logic [RW-1:0] cur, rq, e_ratio;
    logic          e_en;
    cyc++;
    if (rst) begin
      m_h = -100; m_done = -100; m_lo = 0; m_hi = -1; m_rt = 0;
      m_ptr = 0; m_id = 0; m_err = 1'b0; m_run = 1'b0; m_gnt = '0;
      m_old = 1; m_new = 1;
    end else begin
      m_run = run;
      if (cyc >= m_done + 2) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && valid[idx]) w = idx;
        end
        if (w >= 0) begin
          cur   = (cyc >= m_rt) ? m_new : m_old;
          rq    = (w == 0) ? r0 : r1;
          m_h   = cyc;
          m_id  = w;
          m_gnt = 2'(1 << w);
          m_ptr = (w + 1) % NREQ;
          m_err = (rq == 0);
          m_old = cur;
          if (rq == 0 || rq == cur) begin
            m_new = cur; m_done = cyc + 1; m_lo = cyc + 1; m_hi = cyc;
          end else begin
            m_new  = rq;
            m_rt   = cyc + SETTLE;
            m_lo   = cyc + 1;
            m_hi   = cyc + SETTLE;
            m_done = cyc + SETTLE + 2 + int'(rq);
          end
        end
      end
    end
    #1;
    e_ratio = (cyc >= m_rt) ? m_new : m_old;
    e_en    = (cyc >= m_lo && cyc <= m_hi) ? 1'b0 : m_run;
    chk("m_div_ratio", div_ratio, e_ratio);
    chk("m_div_en", div_en, e_en);
    chk("m_ready", ready, (cyc == m_h) ? m_gnt : 2'b00);
    chk("m_busy", busy, (cyc >= m_h && cyc <= m_done) ? 1 : 0);
    chk("m_done", done, (cyc == m_done) ? 1 : 0);
    chk("m_err", err, (cyc == m_done && m_err) ? 1 : 0);
    if (cyc == m_done) chk("m_done_id", done_id, m_id);
  end

  task automatic wait_ready(input string name, output int h, output logic [1:0] g);
    h = -1;
    g = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready != 0) begin
        h = cyc;
        g = ready;
        break;
      end
    end
    if (h < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no REQ_READY in 60 cycles, expected one", name);
    end
  endtask

  task automatic wait_done(input string name, output int d);
    d = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no DONE in 60 cycles, expected one", name);
    end
  endtask

  initial begin
    int         h, d;
    logic [1:0] g;
    rst = 1'b1; run = 1'b0; valid = '0; r0 = '0; r1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", div_en, 0);
    chk("rst_ratio", div_ratio, 1);
    chk("rst_busy", busy, 0);
    run = 1'b1;
    @(negedge clk);
    chk("run_en", div_en, 1);

    // Single change: requester 0 to ratio 3.
    r0 = 3; valid = 2'b01;
    wait_ready("single_ready", h, g);
    valid = '0;
    chk("single_gnt", g, 2'b01);
    @(negedge clk);
    chk("single_gate_h1", div_en, 0);
    repeat (3) @(negedge clk);
    chk("single_ratio_h4", div_ratio, 3);
    chk("single_gate_h4", div_en, 0);
    @(negedge clk);
    chk("single_en_h5", div_en, 1);
    wait_done("single_done", d);
    chk("single_latency", d - h, 9);
    chk("single_id", done_id, 0);

    // Reset mid-DRAIN: requester 1 to ratio 7, then RST at H+2.
    r1 = 7; valid = 2'b10;
    wait_ready("rstmid_ready", h, g);
    valid = '0;
    chk("rstmid_gnt", g, 2'b10);
    repeat (2) @(negedge clk);
    chk("rstmid_gated", div_en, 0);
    rst = 1'b1;
    #1;
    chk("rstmid_en", div_en, 0);
    chk("rstmid_ratio", div_ratio, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", ready, 0);
    chk("rstmid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_en_after", div_en, 1);

    // Round robin with both requesters continuously valid.
    r0 = 2; r1 = 5; valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_ready("rr_ready", h, g);
      chk("rr_gnt", g, (t % 2 == 0) ? 1 : 2);
      if (t == 3) valid = '0;
      wait_done("rr_done", d);
      chk("rr_id", done_id, t % 2);
      chk("rr_ratio", div_ratio, (t % 2 == 0) ? 2 : 5);
      chk("rr_latency", d - h, SETTLE + 2 + ((t % 2 == 0) ? 2 : 5));
    end

    // Same ratio: move to 4, then request 4 again.
    r0 = 4; valid = 2'b01;
    wait_ready("same_pre_ready", h, g);
    valid = '0;
    wait_done("same_pre_done", d);
    r1 = 4; valid = 2'b10;
    wait_ready("same_ready", h, g);
    valid = '0;
    chk("same_gnt", g, 2'b10);
    chk("same_en_h", div_en, 1);
    wait_done("same_done", d);
    chk("same_latency", d - h, 1);
    chk("same_en_d", div_en, 1);
    chk("same_err", err, 0);
    chk("same_ratio", div_ratio, 4);

    // Illegal ratio 0.
    r0 = 0; valid = 2'b01;
    wait_ready("zero_ready", h, g);
    valid = '0;
    chk("zero_gnt", g, 2'b01);
    wait_done("zero_done", d);
    chk("zero_latency", d - h, 1);
    chk("zero_err", err, 1);
    chk("zero_ratio", div_ratio, 4);
    chk("zero_en", div_en, 1);

    // RUN dropped during DRAIN.
    r1 = 6; valid = 2'b10;
    wait_ready("rundrop_ready", h, g);
    valid = '0;
    @(negedge clk);
    run = 1'b0;
    wait_done("rundrop_done", d);
    chk("rundrop_latency", d - h, 12);
    chk("rundrop_ratio", div_ratio, 6);
    chk("rundrop_en", div_en, 0);
    chk("rundrop_id", done_id, 1);

    repeat (2) @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_en", div_en, 1);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Sequencer and arbiter in front of CLK_DIV.
- Arbitrates divide-ratio change requests from NUM_REQ requesters (e.g. UART TX/RX baud configuration) using round-robin.
- Applies each granted change safely: gate CLK_EN low, settle, load DIV_RATIO, re-enable, wait one full output period, then report completion.
- Drives CLK_EN and DIV_RATIO of one CLK_DIV instance directly.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- RATIO_WIDTH, 5, width of divide ratio; matches CLK_DIV DIV_RATIO.
- SETTLE_CYCLES, 4, cycles CLK_EN is held low before a new ratio is applied (≥2).
- RESET_RATIO, 1, DIV_RATIO value after reset.

Ports:
- CLK  in  1  system clock; same clock as CLK_DIV.
- RST  in  1  asynchronous, active-high reset.
- RUN  in  1  global enable; divider output is permitted only while high.
- REQ_VALID  in  NUM_REQ  per-requester change request.
- REQ_RATIO  in  NUM_REQ*RATIO_WIDTH  requested ratios; requester i uses slice [i*RATIO_WIDTH +: RATIO_WIDTH].
- REQ_READY  out  NUM_REQ  one-hot accept strobe.
- DONE  out  1  single-cycle completion pulse.
- DONE_ID  out  2  index of the requester being completed; valid with DONE.
- ERR  out  1  single-cycle pulse with DONE when the requested ratio was 0 (rejected).
- BUSY  out  1  high whenever the state is not IDLE.
- DIV_EN  out  1  to CLK_DIV CLK_EN.
- DIV_RATIO  out  RATIO_WIDTH  to CLK_DIV DIV_RATIO.

Behaviour:
- Reset values (asynchronous, immediate, including mid-sequence):
  - state=IDLE, DIV_EN=0, DIV_RATIO=RESET_RATIO.
  - REQ_READY=0, DONE=0, ERR=0, BUSY=0, DONE_ID=0.
  - Round-robin pointer=0.
- All outputs are registered.
- States: IDLE, GRANT, DRAIN, LOAD, RESUME, FINISH.
- IDLE:
  - DIV_EN follows RUN with one cycle of latency.
  - If any REQ_VALID is high, the round-robin winner is chosen and the state goes to GRANT.
- GRANT (handshake cycle H):
  - REQ_READY[w]=1 for exactly this cycle.
  - Ratio and ID are latched; pointer becomes w+1 mod NUM_REQ.
  - Requesters must hold VALID and RATIO stable until READY; VALID is sampled only in IDLE.
- Decision at the end of GRANT:
  - Ratio 0 → FINISH with ERR=1. DIV_RATIO and DIV_EN are unchanged.
  - Ratio == current DIV_RATIO → FINISH directly; no gating.
  - Otherwise → DRAIN.
- DRAIN:
  - DIV_EN=0 for cycles H+1..H+SETTLE_CYCLES.
  - DIV_RATIO takes the new value on the last DRAIN cycle (H+SETTLE_CYCLES), so it is stable one cycle before re-enable.
- LOAD (one cycle, H+SETTLE_CYCLES+1): DIV_EN = RUN.
- RESUME: a counter runs N cycles (N = new ratio) so one full divided period elapses under the new ratio.
- FINISH:
  - DONE=1 and DONE_ID=latched ID for one cycle; ERR as decided.
  - Returns to IDLE. The next READY is no earlier than 2 cycles after DONE.
- Full latency for a changed ratio: DONE at H+SETTLE_CYCLES+2+N.
- Latency for a same or zero ratio: DONE at H+1.
- Arbitration:
  - The lowest index at or after the pointer wins.
  - A requester dropping VALID before grant is legal; it is simply not served.
  - VALID asserted while BUSY waits; there is no queueing beyond the held VALID.
- RUN low mid-sequence: the sequence still completes and DIV_RATIO updates, but DIV_EN stays 0.
- RUN rising while IDLE: DIV_EN goes high the next cycle.
- Counters are sized to max(SETTLE_CYCLES, 2^RATIO_WIDTH-1) and never wrap. N=1 gives a 1-cycle RESUME.

Decomposition:
- Package clk_div_pkg:
  - state encoding (6 states);
  - RATIO_WIDTH default and RESET_RATIO;
  - ratio-legality function (ratio != 0).
- Sub-module rr_arbiter:
  - inputs: NUM_REQ request vector, pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational; the pointer is registered in clk_div_ctrl.
- The FSM, counters and output registers stay in clk_div_ctrl.

Test Plan:
- Reset/RUN:
  - RST=1 then released, RUN=0 → DIV_EN=0, DIV_RATIO=1, BUSY=0.
  - RUN=1 → DIV_EN=1 one cycle later.
  - RST pulsed mid-DRAIN → all outputs return to reset values immediately.
- Single change:
  - Requester 0 requests ratio 3, SETTLE=4, READY at cycle H.
  - DIV_EN=0 over H+1..H+4; DIV_RATIO=3 from H+4; DIV_EN=1 from H+5.
  - DONE with DONE_ID=0 at H+9.
- Round-robin:
  - Both requesters assert VALID continuously with ratios 2 and 5.
  - Grants alternate 0,1,0,1; each DONE_ID matches its grant; DIV_RATIO alternates 2,5.
- Same ratio: current ratio 4, request 4 → READY at H, DONE at H+1, DIV_EN never drops.
- Illegal ratio: request 0 → DONE and ERR together at H+1; DIV_RATIO unchanged; no gating.
- RUN dropped in DRAIN: ratio 6 requested, RUN=0 at H+2 → DIV_RATIO=6, DONE at H+12, DIV_EN stays 0.
